// File: rtl/priority_arbiter_param_pkg.sv
// Shared constants for the parametrised requester-select arbiter.
// Mode values select fixed priority or round-robin at elaboration.
package priority_arbiter_param_pkg;

   localparam int PA_MODE_FIXED = 0;
   localparam int PA_MODE_RR    = 1;

endpackage

// File: rtl/priority_arbiter_param_pick.sv
// Combinational pick of the first set request searching downward from ptr, wrapping 0 -> N-1.
// Zero latency; no handshake of its own.
module pa_rotate_pick #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] idx,
   output logic         any_req
);

   logic [N-1:0] rot;
   int           p;
   int           src;
   int           pk;
   int           res;

   // rot[N-1] is req[ptr], rot[N-2] is req[ptr-1] and so on, so a plain
   // highest-bit pick on rot yields the first hit of the downward search.
   always_comb begin
      rot = '0;
      p   = int'(ptr);
      src = 0;
      pk  = 0;
      res = 0;
      for (int k = 0; k < N; k++) begin
         src = p - (N - 1 - k);
         if (src < 0) src = src + N;
         rot[k] = req[src[W-1:0]];
      end
      for (int k = 0; k < N; k++) begin
         if (rot[k]) pk = k;
      end
      res = p - (N - 1 - pk);
      if (res < 0) res = res + N;
      idx = res[W-1:0];
   end

   assign any_req = |req;

endmodule

// File: rtl/priority_arbiter_param.sv
// Registered N-way arbiter (fixed highest-index or round-robin); 1 cycle req to grant.
// Grant slot holds while gnt_valid && !gnt_ready; req and pointer are ignored meanwhile.
module priority_arbiter_param
   import priority_arbiter_param_pkg::*;
#(
   parameter  int N       = 8,
   parameter  int RR_MODE = 0,
   localparam int W       = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         gnt_ready,
   output logic         gnt_valid,
   output logic [W-1:0] gnt_idx,
   output logic [N-1:0] gnt_onehot
);

   localparam logic [W-1:0] PTR_TOP = W'(N - 1);

   logic [W-1:0] ptr;
   logic [W-1:0] search_ptr;
   logic [W-1:0] win;
   logic [N-1:0] win_onehot;
   logic         any_req;
   logic         free;

   assign free       = !gnt_valid || gnt_ready;
   assign search_ptr = (RR_MODE == PA_MODE_RR) ? ptr : PTR_TOP;
   assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win;

   pa_rotate_pick #(.N(N), .W(W)) u_pick (
      .req     (req),
      .ptr     (search_ptr),
      .idx     (win),
      .any_req (any_req)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_valid  <= 1'b0;
         gnt_idx    <= '0;
         gnt_onehot <= '0;
         ptr        <= PTR_TOP;
      end else if (free) begin
         if (any_req) begin
            gnt_valid  <= 1'b1;
            gnt_idx    <= win;
            gnt_onehot <= win_onehot;
            // Just-granted line drops to lowest priority; explicit wrap keeps ptr < N.
            if (RR_MODE == PA_MODE_RR)
               ptr <= (win == '0) ? PTR_TOP : win - W'(1);
         end else begin
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
         end
      end
   end

endmodule

// File: doc/priority_arbiter_param.md
Name: priority_arbiter_param

Overview:
Parametrised, registered successor to the team's fixed 8-to-3 priority encoder.
- Accepts N request lines and registers the winning index, plus a one-hot copy, into an output slot with a valid/ready handshake.
- Two modes, selected at elaboration: fixed priority (highest index wins) or round-robin (rotating pointer).
- Intended as the shared requester-select stage in front of buses and other shared resources.

Parameters:
- N, 8: number of request lines; must be ≥ 2; does not have to be a power of two.
- RR_MODE, 0: 0 = fixed priority, highest index wins; 1 = round-robin.
- W, $clog2(N): index width; local/derived, never overridden.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; sampled only when the output slot is free.
- gnt_ready  input  1  consumer accepts the current grant.
- gnt_valid  output  1  output slot holds a grant.
- gnt_idx  output  W  index of the granted request.
- gnt_onehot  output  N  one-hot form of gnt_idx; all zeros when gnt_valid=0.

Behaviour:
- Slot free: `free = !gnt_valid || gnt_ready`, evaluated combinationally each cycle.
- Load condition: on a rising edge where free=1 and `|req`=1:
  - winner loads into gnt_idx and gnt_onehot;
  - gnt_valid becomes 1.
- Empty condition: on a rising edge where free=1 and req=0:
  - gnt_valid becomes 0;
  - gnt_idx becomes 0 and gnt_onehot becomes 0. No X is ever driven, unlike the legacy all-zero case.
- Hold condition: free=0, i.e. gnt_valid=1 and gnt_ready=0:
  - all outputs hold;
  - req is ignored;
  - the pointer holds.
- Latency: 1 cycle from req sampling to a registered grant.
- Throughput: with gnt_ready tied to 1, one grant per cycle (back-to-back loads).
- Fixed mode winner: highest set bit of req. The pointer is unused and holds at its reset value.
- Round-robin pointer: ptr is W bits, range 0..N-1.
- Round-robin winner: the first set bit found by searching from index ptr downward, wrapping from 0 to N-1.
- Round-robin pointer update: on every load, ptr is set to the winner index minus 1, wrapping from 0 to N-1. The just-granted line therefore becomes the lowest priority.
- Pointer and empty/hold: ptr is not updated on empty or hold edges.
- Simultaneous accept and load: gnt_ready=1 with a pending grant and req≠0 in the same cycle:
  - the old grant is consumed;
  - the new grant loads on the same edge;
  - gnt_valid stays 1;
  - the pointer used for that search already reflects the previous load.
- Single requester: a single request always wins, whatever the pointer value.
- Reset values: gnt_valid=0, gnt_idx=0, gnt_onehot=0, ptr=N-1. The first round-robin grant after reset therefore matches fixed priority.
- Reset mid-operation: asserting rst clears all state immediately, without waiting for a clock edge. Any pending grant is discarded and does not need to be handshaken.
- Reset release: the first load can occur on the first rising edge after rst is deasserted.
- Non-power-of-two N: pointer values ≥ N are unreachable. Wrap arithmetic uses explicit compare-to-zero / N-1, never a natural W-bit overflow.

Decomposition:
- Shared header/package holds:
  - mode constants PA_MODE_FIXED=0 and PA_MODE_RR=1;
  - a clog2 helper function, if the toolchain lacks $clog2.
- Sub-module pa_rotate_pick (combinational). Inputs: req and ptr. Outputs: winner index and any_req. Internally:
  - rotate req so that ptr maps to the MSB;
  - apply a fixed highest-bit pick;
  - un-rotate the result.
- Fixed mode instantiates the same sub-module with ptr tied to N-1.
- The top level holds the output register, the pointer, and the handshake logic.

Test Plan:
- Reset: hold rst=1, req=8'hFF, gnt_ready=1 for 5 cycles → gnt_valid=0, gnt_idx=0, gnt_onehot=0 throughout; first edge after release → gnt_idx=7.
- Fixed mode (N=8, RR_MODE=0): req=8'b0010_1100, gnt_ready=1 → next edge gnt_valid=1, gnt_idx=5, gnt_onehot=8'h20; then req=0 → next edge gnt_valid=0, gnt_onehot=0.
- Backpressure: grant idx=5 held with gnt_ready=0 for 4 cycles while req changes to 8'h80 → outputs stay idx=5 and valid=1; on the edge with gnt_ready=1 → gnt_idx=7.
- Round-robin saturation (RR_MODE=1): req=8'hFF, gnt_ready=1 → gnt_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive edges, gnt_valid=1 continuously.
- Round-robin sparse/wrap: req=8'h81 constant → gnt_idx alternates 7,0,7,0; with N=5 and req=5'b10001 → 4,0,4,0, and ptr never exceeds 4.
- Async reset mid-stream: assert rst between edges while gnt_valid=1 in RR mode → outputs read 0 before the next edge; after release with req=8'h03 → first gnt_idx=1, confirming ptr reset to N-1.
